// File: rtl/enemy_wave_controller.sv
// enemy_wave_controller
// Spawns enemies on a frame timer, walks each one back and forth between
// X_MIN and X_MAX, and retires it through a timed DYING phase after a hit.
// One update per frame_clk edge; freeze holds everything except reset.
module enemy_wave_controller #(
    parameter int NUM_ENEMIES    = 4,
    parameter int SPAWN_INTERVAL = 120,
    parameter int DEATH_FRAMES   = 30,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 600,
    parameter int STEP           = 2
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      freeze,
    input  logic                      hit_valid,
    input  logic [2:0]                hit_idx,
    output logic [NUM_ENEMIES-1:0]    enemy_active,
    output logic [NUM_ENEMIES-1:0]    enemy_dying,
    output logic [NUM_ENEMIES-1:0]    enemy_dir,
    output logic [10*NUM_ENEMIES-1:0] enemy_x,
    output logic [7:0]                kill_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DYING = 2'd2;

    localparam int TW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SPAWN_INTERVAL - 1);
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

    // 11-bit copies keep the edge comparisons free of wrap-around
    localparam logic [10:0] XMIN_W = 11'(X_MIN);
    localparam logic [10:0] XMAX_W = 11'(X_MAX);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [9:0]  XMIN_X = 10'(X_MIN);
    localparam logic [9:0]  XMAX_X = 10'(X_MAX);
    localparam logic [9:0]  STEP_X = 10'(STEP);

    logic [TW-1:0]          timer_reg, timer_next;
    logic [7:0]             kill_reg, kill_next;
    logic [NUM_ENEMIES-1:0] idle_vec;
    logic [NUM_ENEMIES-1:0] run_vec;
    logic [NUM_ENEMIES-1:0] grant_vec;
    logic [NUM_ENEMIES-1:0] hit_vec;
    logic                   spawn_due;
    logic                   any_idle;
    logic                   grant_found;
    logic                   hit_in_range;

    assign spawn_due    = (timer_reg == TIMER_LAST);
    assign any_idle     = |idle_vec;
    assign hit_in_range = ({1'b0, hit_idx} < 4'(NUM_ENEMIES));
    assign kill_count   = kill_reg;

    // Grant a due spawn to the lowest-index IDLE slot
    always_comb begin
        grant_vec   = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (idle_vec[i] && !grant_found) begin
                grant_vec[i] = spawn_due && !freeze;
                grant_found  = 1'b1;
            end
        end
    end

    // Spawn timer: wraps after a grant, parks at the last count while no slot is free
    always_comb begin
        timer_next = timer_reg;
        if (!freeze) begin
            if (spawn_due) begin
                if (any_idle)
                    timer_next = '0;
            end else begin
                timer_next = timer_reg + 1'b1;
            end
        end
    end

    // Kill counter saturates at 255
    always_comb begin
        kill_next = kill_reg;
        if ((|hit_vec) && (kill_reg != 8'hFF))
            kill_next = kill_reg + 8'd1;
    end

    // Shared timer and kill counter registers
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            timer_reg <= '0;
            kill_reg  <= '0;
        end else begin
            timer_reg <= timer_next;
            kill_reg  <= kill_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_slot
            logic [1:0]    state_reg, state_next;
            logic [9:0]    x_reg, x_next;
            logic          dir_reg, dir_next;
            logic [DW-1:0] cnt_reg, cnt_next;
            logic [10:0]   x_wide;
            logic          slot_active, slot_dying;

            assign x_wide       = {1'b0, x_reg};
            assign idle_vec[gi] = (state_reg == S_IDLE);
            assign run_vec[gi]  = (state_reg == S_RUN);
            // Hits are only taken by a running slot and never while paused
            assign hit_vec[gi]  = hit_valid && !freeze && hit_in_range &&
                                  (hit_idx == 3'(gi)) && run_vec[gi];

            // Slot state, position, direction and death counter registers
            always_ff @(posedge frame_clk) begin
                if (Reset) begin
                    state_reg <= S_IDLE;
                    x_reg     <= XMAX_X;
                    dir_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    x_reg     <= x_next;
                    dir_reg   <= dir_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Next slot state plus movement; a hit pre-empts that frame's move
            always_comb begin
                state_next = state_reg;
                x_next     = x_reg;
                dir_next   = dir_reg;
                cnt_next   = cnt_reg;
                if (!freeze) begin
                    case (state_reg)
                        S_IDLE: begin
                            if (grant_vec[gi]) begin
                                state_next = S_RUN;
                                x_next     = XMAX_X;
                                dir_next   = 1'b0;
                                cnt_next   = '0;
                            end
                        end
                        S_RUN: begin
                            if (hit_vec[gi]) begin
                                state_next = S_DYING;
                                cnt_next   = '0;
                            end else if (!dir_reg) begin
                                if (x_wide <= XMIN_W + STEP_W) begin
                                    x_next   = XMIN_X;
                                    dir_next = 1'b1;
                                end else begin
                                    x_next = x_reg - STEP_X;
                                end
                            end else begin
                                if (x_wide + STEP_W >= XMAX_W) begin
                                    x_next   = XMAX_X;
                                    dir_next = 1'b0;
                                end else begin
                                    x_next = x_reg + STEP_X;
                                end
                            end
                        end
                        S_DYING: begin
                            if (cnt_reg == DEATH_LAST) begin
                                state_next = S_IDLE;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_next = S_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            // Per-slot outputs decoded from the registered state
            always_comb begin
                slot_active = (state_reg == S_RUN);
                slot_dying  = (state_reg == S_DYING);
            end

            assign enemy_active[gi]     = slot_active;
            assign enemy_dying[gi]      = slot_dying;
            assign enemy_dir[gi]        = dir_reg;
            assign enemy_x[10*gi +: 10] = x_reg;
        end
    endgenerate

endmodule
